// File: rtl/uart_frame_checker.sv
// rtl/uart_frame_checker.sv - UART frame checker: start/data/parity/stop validation with error counting
// Consumes mid-bit samples, reports each completed frame and keeps a saturating error count.
module uart_frame_checker #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 bit_valid,
  input  logic                 sampled_bit,
  input  logic                 clr_count,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_valid,
  output logic                 parity_error,
  output logic                 stop_bit_error,
  output logic                 break_detect,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 frame_done;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_acc;
  logic                 par_err;
  logic                 all_zero;
  logic                 stop1_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else if (bit_valid) begin
      case (state)
        IDLE: begin
          if (!sampled_bit) state_next = DATA;
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) state_next = (PARITY_MODE != 0) ? PARITY : STOP1;
        end
        PARITY: begin
          state_next = STOP1;
        end
        STOP1: begin
          if (STOP_BITS == 2) begin
            state_next = STOP2;
          end else begin
            state_next = IDLE;
            frame_done = 1'b1;
          end
        end
        STOP2: begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // all_zero tracks data, parity and STOP1 samples for break detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt        <= '0;
      shift_reg      <= '0;
      par_acc        <= 1'b0;
      par_err        <= 1'b0;
      all_zero       <= 1'b0;
      stop1_err      <= 1'b0;
      data_out       <= '0;
      frame_valid    <= 1'b0;
      parity_error   <= 1'b0;
      stop_bit_error <= 1'b0;
      break_detect   <= 1'b0;
    end else begin
      frame_valid    <= 1'b0;
      parity_error   <= 1'b0;
      stop_bit_error <= 1'b0;
      break_detect   <= 1'b0;
      if (!enable) begin
        bit_cnt <= '0;
      end else if (bit_valid) begin
        case (state)
          IDLE: begin
            if (!sampled_bit) begin
              bit_cnt   <= '0;
              par_acc   <= 1'b0;
              par_err   <= 1'b0;
              all_zero  <= 1'b1;
              stop1_err <= 1'b0;
            end
          end
          DATA: begin
            shift_reg <= {sampled_bit, shift_reg[DATA_BITS-1:1]};
            par_acc   <= par_acc ^ sampled_bit;
            all_zero  <= all_zero & ~sampled_bit;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            par_err  <= (PARITY_MODE == 2) ? ~(par_acc ^ sampled_bit) : (par_acc ^ sampled_bit);
            all_zero <= all_zero & ~sampled_bit;
          end
          STOP1: begin
            stop1_err <= ~sampled_bit;
            all_zero  <= all_zero & ~sampled_bit;
          end
          default: ;
        endcase
        if (frame_done) begin
          data_out     <= shift_reg;
          frame_valid  <= 1'b1;
          parity_error <= (PARITY_MODE != 0) & par_err;
          if (state == STOP1) begin
            stop_bit_error <= ~sampled_bit;
            break_detect   <= all_zero & ~sampled_bit;
          end else begin
            stop_bit_error <= stop1_err | ~sampled_bit;
            break_detect   <= all_zero;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (enable && frame_valid && (parity_error || stop_bit_error) && err_count != CNT_MAX) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule
